debug_abstract_cmd: RTL and testbench

Abstract-command executor for the RISC-V external debug path. It sits directly downstream of the Debug Module register file. It takes each `command` write, validates it as an Access Register command and sequences the resulting GPR/DPC read or write against the halted hart. It then returns results to `data0` and reports `busy`/`cmderr` back for `abstractcs`.

---
 rtl/debug_abstract_cmd_if.sv | 41 ++++
 rtl/debug_abstract_cmd.sv | 168 ++++++++++++++++
 tb/tb_debug_abstract_cmd.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_abstract_cmd_if.sv
`default_nettype none
// ============================================================================
// Module   : debug_abstract_cmd_if
// Brief    : DM-side and core-side signals of the abstract-command executor
// Revision : 1.0  initial release
// ============================================================================
interface debug_abstract_cmd_if;
    logic        iCmdValid;
    logic [31:0] iCommand;
    logic [2:0]  iCmdErrClr;
    logic        iHalted;
    logic [31:0] iData0;
    logic [31:0] iDpc;
    logic        oBusy;
    logic [2:0]  oCmdErr;
    logic        oData0We;
    logic [31:0] oData0;
    logic        oCommandWe;
    logic [31:0] oCommand;
    logic        oDpcWe;
    logic [31:0] oDpc;
    logic        oRegReq;
    logic        oRegWe;
    logic [4:0]  oRegAddr;
    logic [31:0] oRegWData;
    logic        iRegAck;
    logic [31:0] iRegRData;

    modport slave (
        input  iCmdValid, iCommand, iCmdErrClr, iHalted, iData0, iDpc, iRegAck, iRegRData,
        output oBusy, oCmdErr, oData0We, oData0, oCommandWe, oCommand, oDpcWe, oDpc,
               oRegReq, oRegWe, oRegAddr, oRegWData
    );

    modport master (
        output iCmdValid, iCommand, iCmdErrClr, iHalted, iData0, iDpc, iRegAck, iRegRData,
        input  oBusy, oCmdErr, oData0We, oData0, oCommandWe, oCommand, oDpcWe, oDpc,
               oRegReq, oRegWe, oRegAddr, oRegWData
    );
endinterface
`default_nettype wire

// File: rtl/debug_abstract_cmd.sv
`default_nettype none
// ============================================================================
// Module   : debug_abstract_cmd
// Brief    : Access Register abstract-command executor (GPR / dpc) for the DM
// Revision : 1.0  initial release
// ============================================================================
module debug_abstract_cmd #(
    parameter int TIMEOUT = 64
) (
    input  wire logic           iClk,
    input  wire logic           nRst,
    debug_abstract_cmd_if.slave bus
);
    localparam int          c_CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [15:0] c_REGNO_DPC = 16'h07B1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        REQ   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [31:0]          r_cmd;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_busy;
    logic [2:0]           r_cmdErr;
    logic                 r_data0We;
    logic [31:0]          r_data0;
    logic                 r_commandWe;
    logic [31:0]          r_command;
    logic                 r_dpcWe;
    logic [31:0]          r_dpc;
    logic                 r_regReq;
    logic                 r_regWe;
    logic [4:0]           r_regAddr;
    logic [31:0]          r_regWData;

    logic [15:0]          w_regno;
    logic                 w_isGpr;
    logic                 w_isDpc;
    logic [2:0]           w_chkErr;

    assign w_regno = r_cmd[15:0];
    assign w_isGpr = (w_regno[15:5] == 11'h080);
    assign w_isDpc = (w_regno == c_REGNO_DPC);

    // First failing check wins; halted is checked last so format errors dominate.
    always_comb begin
        w_chkErr = 3'd0;
        if ((r_cmd[31:24] != 8'd0) || (r_cmd[22:20] != 3'd2) || r_cmd[18])
            w_chkErr = 3'd2;
        else if (r_cmd[17] && !w_isGpr && !w_isDpc)
            w_chkErr = 3'd3;
        else if (!bus.iHalted)
            w_chkErr = 3'd4;
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_state     <= IDLE;
            r_cmd       <= 32'd0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_cmdErr    <= 3'd0;
            r_data0We   <= 1'b0;
            r_data0     <= 32'd0;
            r_commandWe <= 1'b0;
            r_command   <= 32'd0;
            r_dpcWe     <= 1'b0;
            r_dpc       <= 32'd0;
            r_regReq    <= 1'b0;
            r_regWe     <= 1'b0;
            r_regAddr   <= 5'd0;
            r_regWData  <= 32'd0;
        end else begin
            r_data0We   <= 1'b0;
            r_commandWe <= 1'b0;
            r_dpcWe     <= 1'b0;

            // Clear first so that any error set later in this cycle overrides it.
            r_cmdErr <= r_cmdErr & ~bus.iCmdErrClr;
            if (bus.iCmdValid && r_busy && (r_cmdErr == 3'd0))
                r_cmdErr <= 3'd1;

            case (r_state)
                IDLE: begin
                    if (bus.iCmdValid && (r_cmdErr == 3'd0)) begin
                        r_cmd   <= bus.iCommand;
                        r_busy  <= 1'b1;
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    if (w_chkErr != 3'd0) begin
                        if (r_cmdErr == 3'd0)
                            r_cmdErr <= w_chkErr;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (!r_cmd[17]) begin
                        r_state <= DONE;
                    end else if (w_isDpc) begin
                        if (r_cmd[16]) begin
                            r_dpcWe <= 1'b1;
                            r_dpc   <= bus.iData0;
                        end else begin
                            r_data0We <= 1'b1;
                            r_data0   <= bus.iDpc;
                        end
                        r_state <= DONE;
                    end else if (r_cmd[16] && (w_regno[4:0] == 5'd0)) begin
                        r_state <= DONE;
                    end else begin
                        r_regReq   <= 1'b1;
                        r_regWe    <= r_cmd[16];
                        r_regAddr  <= w_regno[4:0];
                        r_regWData <= bus.iData0;
                        r_cnt      <= '0;
                        r_state    <= REQ;
                    end
                end
                REQ: begin
                    if (bus.iRegAck) begin
                        r_regReq <= 1'b0;
                        if (!r_regWe) begin
                            r_data0We <= 1'b1;
                            r_data0   <= bus.iRegRData;
                        end
                        r_state <= DONE;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_regReq <= 1'b0;
                        if (r_cmdErr == 3'd0)
                            r_cmdErr <= 3'd3;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                DONE: begin
                    if (r_cmd[19]) begin
                        r_commandWe <= 1'b1;
                        r_command   <= {r_cmd[31:16], w_regno + 16'd1};
                    end
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.oBusy      = r_busy;
    assign bus.oCmdErr    = r_cmdErr;
    assign bus.oData0We   = r_data0We;
    assign bus.oData0     = r_data0;
    assign bus.oCommandWe = r_commandWe;
    assign bus.oCommand   = r_command;
    assign bus.oDpcWe     = r_dpcWe;
    assign bus.oDpc       = r_dpc;
    assign bus.oRegReq    = r_regReq;
    assign bus.oRegWe     = r_regWe;
    assign bus.oRegAddr   = r_regAddr;
    assign bus.oRegWData  = r_regWData;
endmodule
`default_nettype wire

// File: tb/tb_debug_abstract_cmd.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_abstract_cmd
// Brief    : Randomized self-checking bench with a transaction-level model
// Revision : 1.0  initial release
// ============================================================================
module tb_debug_abstract_cmd;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic nRst;
    always #5 clk = ~clk;

    debug_abstract_cmd_if bus();

    debug_abstract_cmd #(.TIMEOUT(TIMEOUT)) dut (
        .iClk (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] mRegs [32];
    logic [31:0] cRegs [32];
    logic [2:0]  mErr;
    int          ackDelay;
    bit          injClr;

    int          busyCyc, reqCyc, reqRun, d0WeCnt, dpcWeCnt, cmdWeCnt, stableErr;
    logic [31:0] lastD0, lastDpc, lastCmd, capWData;
    logic [4:0]  capAddr;
    logic        capWe;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Core regfile responder plus output monitor
    initial begin
        bus.iRegAck   = 1'b0;
        bus.iRegRData = 32'd0;
        reqRun        = 0;
        forever begin
            @(posedge clk); #1;
            bus.iRegAck = 1'b0;
            if (nRst && bus.oRegReq) begin
                reqCyc++;
                reqRun++;
                if (reqRun == 1) begin
                    capAddr  = bus.oRegAddr;
                    capWe    = bus.oRegWe;
                    capWData = bus.oRegWData;
                end else if (capAddr !== bus.oRegAddr || capWe !== bus.oRegWe ||
                             capWData !== bus.oRegWData) begin
                    stableErr++;
                end
                if (ackDelay >= 0 && reqRun == ackDelay + 1) begin
                    bus.iRegAck   = 1'b1;
                    bus.iRegRData = cRegs[bus.oRegAddr];
                    if (bus.oRegWe)
                        cRegs[bus.oRegAddr] = bus.oRegWData;
                end
            end else begin
                reqRun = 0;
                if (($urandom % 6) == 0) begin
                    bus.iRegAck   = 1'b1;
                    bus.iRegRData = $urandom;
                end
            end
            if (bus.oBusy) busyCyc++;
            if (bus.oData0We) begin d0WeCnt++; lastD0 = bus.oData0; end
            if (bus.oDpcWe) begin dpcWeCnt++; lastDpc = bus.oDpc; end
            if (bus.oCommandWe) begin cmdWeCnt++; lastCmd = bus.oCommand; end
        end
    end

    task automatic clear_mon();
        busyCyc = 0; reqCyc = 0; d0WeCnt = 0; dpcWeCnt = 0; cmdWeCnt = 0; stableErr = 0;
    endtask

    task automatic clear_err(input logic [2:0] mask);
        bus.iCmdErrClr = mask;
        @(posedge clk); #1;
        bus.iCmdErrClr = 3'd0;
        mErr = mErr & ~mask;
        chk("cmderr_clr", 32'(bus.oCmdErr), 32'(mErr));
    endtask

    // Predict the whole transaction from the command rules, then run and compare.
    task automatic run_cmd(input logic [31:0] cmd, input bit halted, input logic [31:0] d0,
                           input logic [31:0] dpc, input int dly, input bit wantInj);
        int          regnoI  = int'(cmd[15:0]);
        int          idx     = regnoI - 4096;
        bit          isGpr   = (regnoI >= 'h1000) && (regnoI <= 'h101F);
        bit          isDpc   = (regnoI == 'h07B1);
        bit          wr      = cmd[16];
        bit          ign     = (mErr != 3'd0);
        bit          done    = 1'b0;
        bit          tmo     = 1'b0;
        int          e       = 0;
        int          expBusy = 0;
        int          expReq  = 0;
        int          injAt   = -1;
        int          k       = 0;
        bit          expD0We = 1'b0, expDpcWe = 1'b0, expCmdWe = 1'b0;
        logic [31:0] expD0 = 32'd0, expCmd = 32'd0;

        if (!ign) begin
            if (cmd[31:24] != 8'd0 || cmd[22:20] != 3'd2 || cmd[18]) e = 2;
            else if (cmd[17] && !isGpr && !isDpc) e = 3;
            else if (!halted) e = 4;
            if (e != 0) begin
                expBusy = 1;
            end else begin
                done    = 1'b1;
                expBusy = 2;
                if (cmd[17] && isDpc) begin
                    if (wr) expDpcWe = 1'b1;
                    else begin expD0We = 1'b1; expD0 = dpc; end
                end else if (cmd[17] && !(wr && idx == 0)) begin
                    if (dly >= 0 && dly < TIMEOUT) begin
                        expReq  = dly + 1;
                        expBusy = dly + 3;
                        if (wr) mRegs[idx] = d0;
                        else begin expD0We = 1'b1; expD0 = mRegs[idx]; end
                        if (wantInj) injAt = 2 + int'($urandom_range(dly + 1, 0));
                    end else begin
                        expReq  = TIMEOUT;
                        expBusy = TIMEOUT + 1;
                        done    = 1'b0;
                        tmo     = 1'b1;
                        if (wantInj) injAt = 2 + int'($urandom_range(TIMEOUT - 2, 0));
                    end
                end
                if (done && cmd[19]) begin
                    expCmdWe = 1'b1;
                    expCmd   = {cmd[31:16], cmd[15:0] + 16'd1};
                end
            end
            if (injAt > 0 && mErr == 3'd0) mErr = 3'd1;
            if (e != 0 && mErr == 3'd0) mErr = 3'(e);
            if (tmo && mErr == 3'd0) mErr = 3'd3;
        end

        clear_mon();
        ackDelay       = dly;
        bus.iCommand   = cmd;
        bus.iHalted    = halted;
        bus.iData0     = d0;
        bus.iDpc       = dpc;
        bus.iCmdValid  = 1'b1;
        do begin
            @(posedge clk); #1;
            k++;
            bus.iCmdValid  = (k == injAt);
            bus.iCmdErrClr = (k == injAt && injClr) ? 3'b111 : 3'b000;
            if (k == injAt) bus.iCommand = $urandom;
        end while (bus.oBusy && k < 300);
        bus.iCmdValid  = 1'b0;
        bus.iCmdErrClr = 3'd0;
        chk("busy_bound", 32'(k < 300), 32'd1);
        repeat (2) @(posedge clk);
        #1;

        chk("cmderr", 32'(bus.oCmdErr), 32'(mErr));
        chk("busy_cycles", busyCyc, expBusy);
        chk("req_cycles", reqCyc, expReq);
        chk("data0_we", d0WeCnt, 32'(expD0We));
        if (expD0We) chk("data0", lastD0, expD0);
        chk("dpc_we", dpcWeCnt, 32'(expDpcWe));
        if (expDpcWe) chk("dpc", lastDpc, d0);
        chk("cmd_we", cmdWeCnt, 32'(expCmdWe));
        if (expCmdWe) chk("command", lastCmd, expCmd);
        if (expReq > 0) begin
            chk("req_addr", 32'(capAddr), 32'(idx));
            chk("req_we", 32'(capWe), 32'(wr));
            if (wr) chk("req_wdata", capWData, d0);
        end
        chk("req_stable", stableErr, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] cmd;
        logic [15:0] regno;
        int          sel;
        int          dly;

        nRst           = 1'b0;
        bus.iCmdValid  = 1'b0;
        bus.iCommand   = 32'd0;
        bus.iCmdErrClr = 3'd0;
        bus.iHalted    = 1'b1;
        bus.iData0     = 32'd0;
        bus.iDpc       = 32'd0;
        ackDelay       = 0;
        injClr         = 1'b0;
        mErr           = 3'd0;
        for (int i = 0; i < 32; i++) begin
            cRegs[i] = (i == 0) ? 32'd0 : $urandom;
            mRegs[i] = cRegs[i];
        end
        cRegs[5] = 32'hDEADBEEF;
        mRegs[5] = 32'hDEADBEEF;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.oBusy), 32'd0);
        chk("rst_cmderr", 32'(bus.oCmdErr), 32'd0);
        chk("rst_strobes", 32'({bus.oData0We, bus.oCommandWe, bus.oDpcWe}), 32'd0);
        chk("rst_regreq", 32'(bus.oRegReq), 32'd0);
        chk("rst_data0", bus.oData0, 32'd0);
        chk("rst_command", bus.oCommand, 32'd0);
        chk("rst_dpc", bus.oDpc, 32'd0);
        chk("rst_regaddr", 32'(bus.oRegAddr), 32'd0);
        chk("rst_wdata", bus.oRegWData, 32'd0);
        nRst = 1'b1;
        @(posedge clk); #1;

        run_cmd(32'h00221005, 1'b1, 32'h0, 32'h0, 3, 1'b0);
        run_cmd(32'h002B1007, 1'b1, 32'h12345678, 32'h0, 1, 1'b0);
        chk("core_x7", cRegs[7], 32'h12345678);
        run_cmd(32'h00221000, 1'b0, 32'h0, 32'h0, 0, 1'b0);
        run_cmd(32'h00221005, 1'b1, 32'h0, 32'h0, 0, 1'b0);
        clear_err(3'b111);
        run_cmd(32'h00231000, 1'b1, 32'hCAFEF00D, 32'h0, 0, 1'b0);
        injClr = 1'b1;
        run_cmd(32'h00221001, 1'b1, 32'h0, 32'h0, -1, 1'b1);
        injClr = 1'b0;
        clear_err(3'b111);
        run_cmd(32'h00321001, 1'b1, 32'h0, 32'h0, 0, 1'b0);
        clear_err(3'b111);
        run_cmd(32'h002207B1, 1'b1, 32'h0, 32'h80000010, 0, 1'b0);
        run_cmd(32'h002307B1, 1'b1, 32'hA5A50001, 32'h0, 0, 1'b0);
        run_cmd(32'h00220300, 1'b1, 32'h0, 32'h0, 0, 1'b0);
        clear_err(3'b111);
        run_cmd(32'h0022101F, 1'b1, 32'h0, 32'h0, 0, 1'b0);
        run_cmd(32'h00221020, 1'b1, 32'h0, 32'h0, 0, 1'b0);
        clear_err(3'b111);
        run_cmd(32'h0028FFFF, 1'b1, 32'h0, 32'h0, 0, 1'b0);
        run_cmd(32'h00200005, 1'b0, 32'h0, 32'h0, 0, 1'b0);
        clear_err(3'b111);

        for (int n = 0; n < 120; n++) begin
            sel = int'($urandom % 8);
            if (sel <= 4)      regno = 16'h1000 + 16'($urandom % 32);
            else if (sel == 5) regno = 16'h07B1;
            else if (sel == 6) regno = 16'($urandom);
            else               regno = 16'hFFFF;
            cmd[31:24] = (($urandom % 16) == 0) ? 8'($urandom) : 8'd0;
            cmd[23]    = 1'($urandom);
            cmd[22:20] = (($urandom % 8) == 0) ? 3'($urandom) : 3'd2;
            cmd[19]    = 1'($urandom);
            cmd[18]    = (($urandom % 12) == 0);
            cmd[17]    = (($urandom % 6) != 0);
            cmd[16]    = 1'($urandom);
            cmd[15:0]  = regno;
            dly        = (($urandom % 20) == 0) ? -1 : int'($urandom_range(6, 0));
            injClr     = 1'($urandom);
            run_cmd(cmd, (($urandom % 8) != 0), $urandom, $urandom, dly, (($urandom % 4) == 0));
            if (mErr != 3'd0 && ($urandom % 3) != 0)
                clear_err(3'($urandom_range(7, 1)));
        end
        clear_err(3'b111);

        // Reset while a GPR request is outstanding
        clear_mon();
        ackDelay      = -1;
        bus.iCommand  = 32'h002B1003;
        bus.iHalted   = 1'b1;
        bus.iCmdValid = 1'b1;
        @(posedge clk); #1;
        bus.iCmdValid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_req_before", 32'(bus.oRegReq), 32'd1);
        #2 nRst = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.oBusy), 32'd0);
        chk("midrst_regreq", 32'(bus.oRegReq), 32'd0);
        chk("midrst_regaddr", 32'(bus.oRegAddr), 32'd0);
        chk("midrst_data0", bus.oData0, 32'd0);
        chk("midrst_command", bus.oCommand, 32'd0);
        @(posedge clk); #1;
        nRst = 1'b1;
        mErr = 3'd0;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_no_strobe", 32'(d0WeCnt + cmdWeCnt + dpcWeCnt), 32'd0);
        chk("midrst_idle", 32'(bus.oBusy), 32'd0);
        chk("midrst_cmderr", 32'(bus.oCmdErr), 32'(mErr));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
